// File: rtl/vpe_operand_loader.sv
// Purpose: gathers LANES-wide operand beats into one packed TILE_SIZE tile (vec1/vec2 plus scalar/mode) for the VPE tile.
// Latency: out_valid_o rises 1 cycle after the final beat is accepted; minimum tile period is BEATS+1 cycles.
// Backpressure: in_ready_o drops for the whole ISSUE phase; the tile is held stable until out_ready_i completes the handshake.
// Optional feature: define VPE_LOADER_ZPAD_EN to let in_last_i close a short tile (the rest of the tile stays zero).
module vpe_operand_loader #(
  parameter int TILE_SIZE = 128,
  parameter int MUL_WIDTH = 16,
  parameter int LANES     = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  input  logic [LANES*MUL_WIDTH-1:0]               in_op1_i,
  input  logic [LANES*MUL_WIDTH-1:0]               in_op2_i,
  input  logic [MUL_WIDTH-1:0]                     in_scal_i,
  input  logic                                     in_mode_i,
  input  logic                                     in_last_i,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [TILE_SIZE*MUL_WIDTH-1:0]           vec1_o,
  output logic [TILE_SIZE*MUL_WIDTH-1:0]           vec2_o,
  output logic [MUL_WIDTH-1:0]                     scal_o,
  output logic                                     mode_o,
  output logic [$clog2(TILE_SIZE/LANES+1)-1:0]     valid_beats_o
);

  localparam int BEATS = TILE_SIZE / LANES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int BW    = LANES * MUL_WIDTH;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic [CW-1:0]                 beat_cnt;
  logic [TILE_SIZE*MUL_WIDTH-1:0] vec1_q;
  logic [TILE_SIZE*MUL_WIDTH-1:0] vec2_q;
  logic [MUL_WIDTH-1:0]          scal_q;
  logic                          mode_q;
  logic                          accept;
  logic                          final_beat;
  logic                          issue_done;

  // Ready is gated by reset so nothing can be taken while the loader is held.
  assign in_ready_o = ~rst_i & (state != ISSUE);
  assign accept     = in_valid_i & in_ready_o;
  assign issue_done = (state == ISSUE) & out_ready_i;

`ifdef VPE_LOADER_ZPAD_EN
  // A marked last beat closes the tile early; on beat BEATS-1 it changes nothing.
  assign final_beat = (beat_cnt == LAST_BEAT) | in_last_i;
`else
  // Tiles are always full length; the last marker is deliberately dropped.
  logic unused_last;
  assign unused_last = in_last_i;
  assign final_beat  = (beat_cnt == LAST_BEAT);
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: beat 0 leaves IDLE, final beat enters ISSUE, handshake returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = final_beat ? ISSUE : FILL;
      FILL:    if (accept && final_beat) state_nxt = ISSUE;
      ISSUE:   if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter: doubles as the write slot and as the beat count reported at issue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           beat_cnt <= '0;
    else if (issue_done) beat_cnt <= '0;
    else if (accept)     beat_cnt <= beat_cnt + CW'(1);
  end

  // Tile storage: each accepted beat lands in its slot; cleared after issue so unwritten slots read zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vec1_q <= '0;
      vec2_q <= '0;
    end else if (issue_done) begin
      vec1_q <= '0;
      vec2_q <= '0;
    end else if (accept) begin
      for (int b = 0; b < BEATS; b++) begin
        if (beat_cnt == CW'(b)) begin
          vec1_q[b*BW +: BW] <= in_op1_i;
          vec2_q[b*BW +: BW] <= in_op2_i;
        end
      end
    end
  end

  // Scalar and mode belong to the tile's first beat only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scal_q <= '0;
      mode_q <= 1'b0;
    end else if (accept && (state == IDLE)) begin
      scal_q <= in_scal_i;
      mode_q <= in_mode_i;
    end
  end

  assign out_valid_o   = (state == ISSUE);
  assign vec1_o        = vec1_q;
  assign vec2_o        = vec2_q;
  assign scal_o        = scal_q;
  assign mode_o        = mode_q;
  assign valid_beats_o = beat_cnt;

endmodule

// File: doc/vpe_operand_loader.md
VPE_OPERAND_LOADER -- requirements
Module: vpe_operand_loader

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 128: elements per tile vector.
REQ-002 SHALL have parameter MUL_WIDTH, default 16: element width in bits.
REQ-003 SHALL have parameter LANES, default 8: elements per input beat; BEATS = TILE_SIZE/LANES (default 16).
REQ-004 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid_i, input, 1: input beat valid.
REQ-007 SHALL have port in_ready_o, output, 1: loader accepts a beat.
REQ-008 SHALL have port in_op1_i, input, LANES*MUL_WIDTH: operand-1 elements; lane 0 in the LSBs.
REQ-009 SHALL have port in_op2_i, input, LANES*MUL_WIDTH: operand-2 elements; lane 0 in the LSBs.
REQ-010 SHALL have port in_scal_i, input, MUL_WIDTH: scalar operand.
REQ-011 SHALL have port in_mode_i, input, 1: 1 = scalar mode, 0 = vector mode.
REQ-012 SHALL have port in_last_i, input, 1: final beat of the tile.
REQ-013 SHALL have port out_valid_o, output, 1: tile ready for the VPE tile.
REQ-014 SHALL have port out_ready_i, input, 1: VPE tile accepts.
REQ-015 SHALL have ports vec1_o and vec2_o, output, TILE_SIZE*MUL_WIDTH each: packed tile vectors.
REQ-016 SHALL have ports scal_o (output, MUL_WIDTH) and mode_o (output, 1): the tile's scalar and mode.
REQ-017 SHALL have port valid_beats_o, output, $clog2(BEATS+1): number of beats written into the issued tile.

Function
REQ-018 SHALL implement a state machine with states IDLE, FILL and ISSUE.
REQ-019 SHALL drive in_ready_o = 1 in IDLE and FILL, and 0 in ISSUE.
REQ-020 SHALL define an accepted beat as in_valid_i && in_ready_o at a rising clock edge.
REQ-021 SHALL write accepted beat k (k = 0..BEATS-1) into elements [k*LANES +: LANES] of both vectors.
REQ-022 SHALL capture scal and mode only on beat 0 (IDLE accept) and ignore them on later beats.
REQ-023 SHALL transition on beat 0: IDLE to FILL, or IDLE to ISSUE when BEATS == 1.
REQ-024 SHALL transition FILL to ISSUE on accepting beat BEATS-1; out_valid_o SHALL assert on the next cycle (latency 1).
REQ-025 SHALL keep out_valid_o = 1 throughout ISSUE, with every output held stable until out_ready_i = 1.
REQ-026 SHALL transition ISSUE to IDLE on out_valid_o && out_ready_i, clearing the beat counter and both vectors to zero.
REQ-027 SHALL keep out_valid_o = 0 outside ISSUE; minimum tile period is BEATS+1 cycles.
REQ-028 SHALL drive zero for every unwritten element at issue.
REQ-029 SHALL ignore in_valid_i while in ISSUE.
REQ-030 SHALL ignore in_last_i except as REQ-036 specifies.

Reset
REQ-031 SHALL, while rst_i = 1 and asynchronously, force: state IDLE, beat counter 0, out_valid_o 0, vec1_o/vec2_o/scal_o/mode_o/valid_beats_o 0.
REQ-032 SHALL hold in_ready_o at 0 while rst_i = 1; in_ready_o SHALL rise in the first cycle after deassertion.
REQ-033 SHALL discard any partial tile when reset occurs mid-FILL or mid-ISSUE, with no output handshake.

Configuration
REQ-034 SHALL compile short-tile zero padding in only when macro VPE_LOADER_ZPAD_EN is defined.
REQ-035 SHALL, without VPE_LOADER_ZPAD_EN, ignore in_last_i and drive valid_beats_o = BEATS at issue.
REQ-036 SHALL, with VPE_LOADER_ZPAD_EN, go to ISSUE when in_last_i = 1 on accepted beat k < BEATS-1, leave remaining elements zero, and drive valid_beats_o = k+1.
REQ-037 SHALL, with VPE_LOADER_ZPAD_EN, treat in_last_i on beat BEATS-1 exactly as a normal final beat.

Verification
REQ-038 SHALL cover full tile: 16 back-to-back beats with element value = index, mode = 0 -> out_valid_o at cycle 17; vec1_o[i] = i; valid_beats_o = 16.
REQ-039 SHALL cover backpressure: out_ready_i = 0 for 5 cycles in ISSUE -> outputs stable and in_ready_o = 0; handshake in cycle 6 -> IDLE, vectors zero.
REQ-040 SHALL cover input gaps: in_valid_i toggling 1/0 -> tile issues after 16 accepted beats, element order preserved.
REQ-041 SHALL cover scalar capture: beat 0 scal = 16'h3C00, mode = 1, later beats scal = 16'hFFFF -> scal_o = 16'h3C00, mode_o = 1.
REQ-042 SHALL cover reset mid-FILL: rst_i pulse after beat 7, then 16 new beats -> no stale data; tile equals the new beats only.
REQ-043 SHALL cover padding with VPE_LOADER_ZPAD_EN: in_last_i on beat 3 -> issue with valid_beats_o = 4 and elements 32..127 zero; without the macro -> in_last_i ignored and issue after 16 beats.
